// File: rtl/plab2_proc_mem_arbiter_if.sv
// Valid/ready message channel with a one-bit security-domain sideband.
// The master drives msg/val/domain and the slave drives rdy.
interface plab2_proc_mem_arbiter_if #(
  parameter int unsigned p_nbits = 77
);
  logic [p_nbits-1:0] msg;
  logic               val;
  logic               rdy;
  logic               domain;

  modport master (output msg, output val, output domain, input rdy);
  modport slave  (input msg, input val, input domain, output rdy);
endinterface

// File: rtl/plab2_proc_mem_arbiter.sv
// Two-port imem/dmem request arbiter feeding a single memory port through a registered slot.
// Responses are steered back by the port tag carried in opaque[7].
module plab2_proc_mem_arbiter #(
  parameter int unsigned p_max_outstanding = 4,
  parameter int unsigned p_req_nbits       = 77,
  parameter int unsigned p_resp_nbits      = 45
) (
  input  logic                             clk,
  input  logic                             reset,
  plab2_proc_mem_arbiter_if.slave          in0_req,
  plab2_proc_mem_arbiter_if.slave          in1_req,
  plab2_proc_mem_arbiter_if.master         out_req,
  plab2_proc_mem_arbiter_if.slave          mem_resp,
  plab2_proc_mem_arbiter_if.master         out0_resp,
  plab2_proc_mem_arbiter_if.master         out1_resp,
  output logic                             stray_resp
);

  // Bit position of opaque[7] in each message layout.
  localparam int unsigned c_req_tag  = p_req_nbits - 4;
  localparam int unsigned c_resp_tag = p_resp_nbits - 4;
  localparam logic [3:0]  c_max      = 4'(p_max_outstanding);

  logic [p_req_nbits-1:0]  r_slot_msg;
  logic                    r_slot_val;
  logic                    r_slot_dom;
  logic                    r_rr;
  logic [3:0]              r_cnt0;
  logic [3:0]              r_cnt1;
  logic                    r_stray;

  logic [p_req_nbits-1:0]  w_slot_msg_d;
  logic                    w_slot_val_d;
  logic                    w_slot_dom_d;
  logic                    w_rr_d;
  logic [3:0]              w_cnt0_d;
  logic [3:0]              w_cnt1_d;
  logic                    w_stray_d;

  logic                    w_slot_accept;
  logic                    w_elig0;
  logic                    w_elig1;
  logic                    w_gnt_val;
  logic                    w_gnt_id;
  logic [p_req_nbits-1:0]  w_gnt_msg;
  logic                    w_gnt_dom;

  logic                    w_dst;
  logic [p_resp_nbits-1:0] w_resp_msg;
  logic                    w_resp_fire;
  logic                    w_fire0;
  logic                    w_fire1;
  logic                    w_cnt_dst_zero;

  //--------------------------------------------------------------------------
  // Request arbitration
  //--------------------------------------------------------------------------

  assign w_slot_accept = !r_slot_val || out_req.rdy;
  assign w_elig0 = !reset && in0_req.val && (r_cnt0 < c_max) && w_slot_accept;
  assign w_elig1 = !reset && in1_req.val && (r_cnt1 < c_max) && w_slot_accept;

  always_comb begin
    w_gnt_val = 1'b0;
    w_gnt_id  = 1'b0;
    if (w_elig0 && w_elig1) begin
      w_gnt_val = 1'b1;
      w_gnt_id  = r_rr;
    end else if (w_elig0) begin
      w_gnt_val = 1'b1;
      w_gnt_id  = 1'b0;
    end else if (w_elig1) begin
      w_gnt_val = 1'b1;
      w_gnt_id  = 1'b1;
    end
  end

  assign in0_req.rdy = w_gnt_val && !w_gnt_id;
  assign in1_req.rdy = w_gnt_val && w_gnt_id;

  // The port id replaces opaque[7] so the response can find its way home.
  always_comb begin
    w_gnt_msg            = w_gnt_id ? in1_req.msg : in0_req.msg;
    w_gnt_msg[c_req_tag] = w_gnt_id;
    w_gnt_dom            = w_gnt_id ? in1_req.domain : in0_req.domain;
  end

  always_comb begin
    w_slot_msg_d = r_slot_msg;
    w_slot_val_d = r_slot_val;
    w_slot_dom_d = r_slot_dom;
    w_rr_d       = r_rr;
    if (r_slot_val && out_req.rdy) begin
      w_slot_val_d = 1'b0;
    end
    if (w_gnt_val) begin
      w_slot_msg_d = w_gnt_msg;
      w_slot_val_d = 1'b1;
      w_slot_dom_d = w_gnt_dom;
      w_rr_d       = !w_gnt_id;
    end
  end

  assign out_req.msg    = r_slot_msg;
  assign out_req.val    = r_slot_val;
  assign out_req.domain = r_slot_dom;

  //--------------------------------------------------------------------------
  // Response steering (purely combinational)
  //--------------------------------------------------------------------------

  assign w_dst = mem_resp.msg[c_resp_tag];

  always_comb begin
    w_resp_msg             = mem_resp.msg;
    w_resp_msg[c_resp_tag] = 1'b0;
  end

  assign out0_resp.msg    = w_resp_msg;
  assign out1_resp.msg    = w_resp_msg;
  assign out0_resp.val    = mem_resp.val && !w_dst;
  assign out1_resp.val    = mem_resp.val && w_dst;
  assign out0_resp.domain = mem_resp.domain;
  assign out1_resp.domain = mem_resp.domain;
  assign mem_resp.rdy     = !reset && (w_dst ? out1_resp.rdy : out0_resp.rdy);

  assign w_resp_fire    = mem_resp.val && mem_resp.rdy;
  assign w_fire0        = w_resp_fire && !w_dst;
  assign w_fire1        = w_resp_fire && w_dst;
  assign w_cnt_dst_zero = w_dst ? (r_cnt1 == 4'd0) : (r_cnt0 == 4'd0);

  //--------------------------------------------------------------------------
  // Outstanding counters
  //--------------------------------------------------------------------------

  // A grant and a completion on the same port cancel; a stray completion saturates at 0.
  function automatic logic [3:0] cnt_next(logic [3:0] cnt, logic inc, logic dec);
    logic [3:0] res;
    res = cnt;
    if (inc && !dec) begin
      res = cnt + 4'd1;
    end else if (dec && !inc && (cnt != 4'd0)) begin
      res = cnt - 4'd1;
    end
    return res;
  endfunction

  always_comb begin
    w_cnt0_d  = cnt_next(r_cnt0, in0_req.rdy, w_fire0);
    w_cnt1_d  = cnt_next(r_cnt1, in1_req.rdy, w_fire1);
    w_stray_d = w_resp_fire && w_cnt_dst_zero;
  end

  assign stray_resp = r_stray;

  //--------------------------------------------------------------------------
  // State
  //--------------------------------------------------------------------------

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_slot_msg <= '0;
      r_slot_val <= 1'b0;
      r_slot_dom <= 1'b0;
      r_rr       <= 1'b0;
      r_cnt0     <= 4'd0;
      r_cnt1     <= 4'd0;
      r_stray    <= 1'b0;
    end else begin
      r_slot_msg <= w_slot_msg_d;
      r_slot_val <= w_slot_val_d;
      r_slot_dom <= w_slot_dom_d;
      r_rr       <= w_rr_d;
      r_cnt0     <= w_cnt0_d;
      r_cnt1     <= w_cnt1_d;
      r_stray    <= w_stray_d;
    end
  end

  a_cnt_bound: assert property (@(posedge clk) (r_cnt0 <= c_max) && (r_cnt1 <= c_max));

endmodule

// File: tb/tb_plab2_proc_mem_arbiter.sv
// Directed bench for plab2_proc_mem_arbiter with hand-computed expectations.
module tb_plab2_proc_mem_arbiter;

  logic clk;
  logic reset;
  logic stray_resp;

  int n_tests;
  int n_fail;

  plab2_proc_mem_arbiter_if #(.p_nbits(77)) in0_req_if ();
  plab2_proc_mem_arbiter_if #(.p_nbits(77)) in1_req_if ();
  plab2_proc_mem_arbiter_if #(.p_nbits(77)) out_req_if ();
  plab2_proc_mem_arbiter_if #(.p_nbits(45)) mem_resp_if ();
  plab2_proc_mem_arbiter_if #(.p_nbits(45)) out0_resp_if ();
  plab2_proc_mem_arbiter_if #(.p_nbits(45)) out1_resp_if ();

  plab2_proc_mem_arbiter #(
    .p_max_outstanding (4),
    .p_req_nbits       (77),
    .p_resp_nbits      (45)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .in0_req    (in0_req_if.slave),
    .in1_req    (in1_req_if.slave),
    .out_req    (out_req_if.master),
    .mem_resp   (mem_resp_if.slave),
    .out0_resp  (out0_resp_if.master),
    .out1_resp  (out1_resp_if.master),
    .stray_resp (stray_resp)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [76:0] mk_req(logic [2:0] typ, logic [7:0] op, logic [31:0] addr,
                                         logic [31:0] data);
    return {typ, op, addr, 2'd0, data};
  endfunction

  function automatic logic [44:0] mk_resp(logic [2:0] typ, logic [7:0] op, logic [31:0] data);
    return {typ, op, 2'd0, data};
  endfunction

  task automatic check_eq(input string tag, input logic [76:0] obs, input logic [76:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  logic [76:0] exp_slot;
  logic [76:0] req_a;
  logic [76:0] req_c;

  initial begin
    n_tests = 0;
    n_fail  = 0;
    reset   = 1'b1;
    in0_req_if.msg = '0; in0_req_if.val = 1'b0; in0_req_if.domain = 1'b0;
    in1_req_if.msg = '0; in1_req_if.val = 1'b0; in1_req_if.domain = 1'b0;
    out_req_if.rdy = 1'b0;
    mem_resp_if.msg = '0; mem_resp_if.val = 1'b0; mem_resp_if.domain = 1'b0;
    out0_resp_if.rdy = 1'b0;
    out1_resp_if.rdy = 1'b0;

    // Reset state and reset-time handshake behaviour.
    #2;
    in0_req_if.val   = 1'b1;
    mem_resp_if.val  = 1'b1;
    mem_resp_if.msg  = mk_resp(3'd0, 8'h00, 32'h1234);
    out0_resp_if.rdy = 1'b1;
    #1;
    check_eq("rst_in0_rdy", 77'(in0_req_if.rdy), 77'd0);
    check_eq("rst_out0_val", 77'(out0_resp_if.val), 77'd1);
    check_eq("rst_mem_rdy", 77'(mem_resp_if.rdy), 77'd0);
    check_eq("rst_out_val", 77'(out_req_if.val), 77'd0);
    check_eq("rst_out_msg", out_req_if.msg, 77'd0);
    check_eq("rst_out_dom", 77'(out_req_if.domain), 77'd0);
    check_eq("rst_stray", 77'(stray_resp), 77'd0);
    check_eq("rst_cnt0", 77'(dut.r_cnt0), 77'd0);
    check_eq("rst_cnt1", 77'(dut.r_cnt1), 77'd0);
    in0_req_if.val  = 1'b0;
    mem_resp_if.val = 1'b0;
    tick();
    tick();
    reset = 1'b0;

    // Single imem read.
    in0_req_if.val    = 1'b1;
    in0_req_if.msg    = mk_req(3'd0, 8'h00, 32'h1000, 32'h0);
    in0_req_if.domain = 1'b1;
    #4;
    check_eq("t1_in0_rdy", 77'(in0_req_if.rdy), 77'd1);
    check_eq("t1_in1_rdy", 77'(in1_req_if.rdy), 77'd0);
    tick();
    in0_req_if.val = 1'b0;
    check_eq("t1_out_val", 77'(out_req_if.val), 77'd1);
    check_eq("t1_out_msg", out_req_if.msg, mk_req(3'd0, 8'h00, 32'h1000, 32'h0));
    check_eq("t1_out_dom", 77'(out_req_if.domain), 77'd1);
    check_eq("t1_cnt0_1", 77'(dut.r_cnt0), 77'd1);
    out_req_if.rdy = 1'b1;
    tick();
    out_req_if.rdy = 1'b0;
    check_eq("t1_drained", 77'(out_req_if.val), 77'd0);
    mem_resp_if.val    = 1'b1;
    mem_resp_if.msg    = mk_resp(3'd0, 8'h00, 32'hDEADBEEF);
    mem_resp_if.domain = 1'b1;
    out0_resp_if.rdy   = 1'b1;
    #4;
    check_eq("t1_r_out0_val", 77'(out0_resp_if.val), 77'd1);
    check_eq("t1_r_out1_val", 77'(out1_resp_if.val), 77'd0);
    check_eq("t1_r_msg", 77'(out0_resp_if.msg), 77'(mk_resp(3'd0, 8'h00, 32'hDEADBEEF)));
    check_eq("t1_r_dom", 77'(out0_resp_if.domain), 77'd1);
    check_eq("t1_r_mem_rdy", 77'(mem_resp_if.rdy), 77'd1);
    tick();
    mem_resp_if.val    = 1'b0;
    mem_resp_if.domain = 1'b0;
    in0_req_if.domain  = 1'b0;
    check_eq("t1_cnt0_0", 77'(dut.r_cnt0), 77'd0);
    check_eq("t1_stray", 77'(stray_resp), 77'd0);

    // Alternating grants with responses returned each cycle.
    do_reset();
    out_req_if.rdy   = 1'b1;
    out0_resp_if.rdy = 1'b1;
    out1_resp_if.rdy = 1'b1;
    exp_slot = '0;
    for (int k = 0; k < 5; k++) begin
      if (k < 4) begin
        in0_req_if.val = 1'b1;
        in0_req_if.msg = mk_req(3'd0, 8'(k), 32'h2000 + 32'(k * 4), 32'h0);
        in1_req_if.val = 1'b1;
        in1_req_if.msg = mk_req(3'd1, 8'h05, 32'h3000 + 32'(k * 4), 32'hA0 + 32'(k));
      end else begin
        in0_req_if.val = 1'b0;
        in1_req_if.val = 1'b0;
      end
      if (k >= 1) begin
        mem_resp_if.val = 1'b1;
        mem_resp_if.msg = mk_resp(3'd0, ((k - 1) % 2 == 1) ? 8'h80 : 8'h00, 32'hC0 + 32'(k));
      end else begin
        mem_resp_if.val = 1'b0;
      end
      #4;
      if (k < 4) begin
        check_eq("t2_in0_rdy", 77'(in0_req_if.rdy), 77'(k % 2 == 0));
        check_eq("t2_in1_rdy", 77'(in1_req_if.rdy), 77'(k % 2 == 1));
      end
      if (k >= 1) begin
        check_eq("t2_out_msg", out_req_if.msg, exp_slot);
        if ((k - 1) % 2 == 1) begin
          check_eq("t2_out1_val", 77'(out1_resp_if.val), 77'd1);
          check_eq("t2_out0_val", 77'(out0_resp_if.val), 77'd0);
          check_eq("t2_out1_msg", 77'(out1_resp_if.msg),
                   77'(mk_resp(3'd0, 8'h00, 32'hC0 + 32'(k))));
        end else begin
          check_eq("t2_out0_val", 77'(out0_resp_if.val), 77'd1);
          check_eq("t2_out1_val", 77'(out1_resp_if.val), 77'd0);
        end
      end
      if (k % 2 == 0) exp_slot = mk_req(3'd0, 8'(k), 32'h2000 + 32'(k * 4), 32'h0);
      else            exp_slot = mk_req(3'd1, 8'h85, 32'h3000 + 32'(k * 4), 32'hA0 + 32'(k));
      tick();
    end
    mem_resp_if.val = 1'b0;
    check_eq("t2_cnt0", 77'(dut.r_cnt0), 77'd0);
    check_eq("t2_cnt1", 77'(dut.r_cnt1), 77'd0);

    // Port 1 hits the outstanding limit; port 0 keeps going.
    for (int k = 0; k < 4; k++) begin
      in1_req_if.val = 1'b1;
      in1_req_if.msg = mk_req(3'd1, 8'h10 + 8'(k), 32'h6000 + 32'(k * 4), 32'(k));
      #4;
      check_eq("t3_in1_rdy", 77'(in1_req_if.rdy), 77'd1);
      tick();
    end
    in0_req_if.val = 1'b1;
    in0_req_if.msg = mk_req(3'd0, 8'h20, 32'h7000, 32'h0);
    #4;
    check_eq("t3_in1_full", 77'(in1_req_if.rdy), 77'd0);
    check_eq("t3_in0_ok", 77'(in0_req_if.rdy), 77'd1);
    tick();
    in0_req_if.val  = 1'b0;
    mem_resp_if.val = 1'b1;
    mem_resp_if.msg = mk_resp(3'd0, 8'h80, 32'h1);
    #4;
    check_eq("t3_in1_still", 77'(in1_req_if.rdy), 77'd0);
    check_eq("t3_mem_rdy", 77'(mem_resp_if.rdy), 77'd1);
    check_eq("t3_out1_val", 77'(out1_resp_if.val), 77'd1);
    tick();
    mem_resp_if.val = 1'b0;
    #4;
    check_eq("t3_in1_back", 77'(in1_req_if.rdy), 77'd1);
    tick();
    in1_req_if.val = 1'b0;
    for (int j = 0; j < 5; j++) begin
      mem_resp_if.val = 1'b1;
      mem_resp_if.msg = mk_resp(3'd0, (j < 4) ? 8'h80 : 8'h00, 32'(j));
      tick();
    end
    mem_resp_if.val = 1'b0;
    check_eq("t3_cnt0", 77'(dut.r_cnt0), 77'd0);
    check_eq("t3_cnt1", 77'(dut.r_cnt1), 77'd0);

    // Stall with the slot full.
    out_req_if.rdy = 1'b0;
    req_a = mk_req(3'd0, 8'h21, 32'h4000, 32'h0);
    req_c = mk_req(3'd1, 8'h33, 32'h5000, 32'h55);
    in0_req_if.val = 1'b1;
    in0_req_if.msg = req_a;
    tick();
    in0_req_if.msg = mk_req(3'd0, 8'h22, 32'h4004, 32'h0);
    in1_req_if.val = 1'b1;
    in1_req_if.msg = req_c;
    for (int s = 0; s < 3; s++) begin
      #4;
      check_eq("t4_stable_msg", out_req_if.msg, req_a);
      check_eq("t4_stable_val", 77'(out_req_if.val), 77'd1);
      check_eq("t4_in0_rdy", 77'(in0_req_if.rdy), 77'd0);
      check_eq("t4_in1_rdy", 77'(in1_req_if.rdy), 77'd0);
      tick();
    end
    out_req_if.rdy = 1'b1;
    #4;
    check_eq("t4_rel_in1", 77'(in1_req_if.rdy), 77'd1);
    check_eq("t4_rel_in0", 77'(in0_req_if.rdy), 77'd0);
    tick();
    in0_req_if.val = 1'b0;
    in1_req_if.val = 1'b0;
    check_eq("t4_next_msg", out_req_if.msg, mk_req(3'd1, 8'hB3, 32'h5000, 32'h55));
    tick();
    mem_resp_if.val = 1'b1;
    mem_resp_if.msg = mk_resp(3'd0, 8'h00, 32'h0);
    tick();
    mem_resp_if.msg = mk_resp(3'd0, 8'h80, 32'h0);
    tick();
    mem_resp_if.val = 1'b0;
    check_eq("t4_cnt0", 77'(dut.r_cnt0), 77'd0);
    check_eq("t4_cnt1", 77'(dut.r_cnt1), 77'd0);
    tick();

    // Stray response and same-cycle grant/completion.
    mem_resp_if.val = 1'b1;
    mem_resp_if.msg = mk_resp(3'd0, 8'h00, 32'h5A5A);
    #4;
    check_eq("t5_out0_val", 77'(out0_resp_if.val), 77'd1);
    tick();
    mem_resp_if.val = 1'b0;
    check_eq("t5_stray_hi", 77'(stray_resp), 77'd1);
    check_eq("t5_cnt0", 77'(dut.r_cnt0), 77'd0);
    tick();
    check_eq("t5_stray_lo", 77'(stray_resp), 77'd0);
    in1_req_if.val = 1'b1;
    in1_req_if.msg = mk_req(3'd0, 8'h40, 32'h8000, 32'h0);
    tick();
    check_eq("t5_cnt1_1", 77'(dut.r_cnt1), 77'd1);
    mem_resp_if.val = 1'b1;
    mem_resp_if.msg = mk_resp(3'd0, 8'h80, 32'h0);
    #4;
    check_eq("t5_same_rdy", 77'(in1_req_if.rdy), 77'd1);
    tick();
    in1_req_if.val  = 1'b0;
    check_eq("t5_cnt1_same", 77'(dut.r_cnt1), 77'd1);
    check_eq("t5_no_stray", 77'(stray_resp), 77'd0);
    tick();
    mem_resp_if.val = 1'b0;
    check_eq("t5_cnt1_0", 77'(dut.r_cnt1), 77'd0);

    // Asynchronous reset mid-cycle with the slot full and cnt0 = 3.
    for (int k = 0; k < 3; k++) begin
      in0_req_if.val = 1'b1;
      in0_req_if.msg = mk_req(3'd0, 8'h50 + 8'(k), 32'h9000 + 32'(k * 4), 32'h0);
      tick();
    end
    in0_req_if.val = 1'b0;
    out_req_if.rdy = 1'b0;
    check_eq("t6_pre_val", 77'(out_req_if.val), 77'd1);
    check_eq("t6_pre_cnt0", 77'(dut.r_cnt0), 77'd3);
    check_eq("t6_pre_rr", 77'(dut.r_rr), 77'd1);
    #2;
    reset = 1'b1;
    #1;
    check_eq("t6_val", 77'(out_req_if.val), 77'd0);
    check_eq("t6_msg", out_req_if.msg, 77'd0);
    check_eq("t6_cnt0", 77'(dut.r_cnt0), 77'd0);
    check_eq("t6_rr", 77'(dut.r_rr), 77'd0);
    #2;
    reset = 1'b0;
    tick();
    mem_resp_if.val = 1'b1;
    mem_resp_if.msg = mk_resp(3'd0, 8'h00, 32'h77);
    #4;
    check_eq("t6_resp_val", 77'(out0_resp_if.val), 77'd1);
    tick();
    mem_resp_if.val = 1'b0;
    check_eq("t6_stray", 77'(stray_resp), 77'd1);
    out_req_if.rdy = 1'b1;
    in0_req_if.val = 1'b1;
    in1_req_if.val = 1'b1;
    #4;
    check_eq("t6_gnt0", 77'(in0_req_if.rdy), 77'd1);
    check_eq("t6_gnt1", 77'(in1_req_if.rdy), 77'd0);
    tick();
    in0_req_if.val = 1'b0;
    in1_req_if.val = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
